// File: rtl/reg_dump_unit.sv
// Register-file dump engine: walks registers 0..CELDAS-1 and streams each one
// MSB byte first through a one-byte-at-a-time transmitter handshake.
module reg_dump_unit #(
  parameter int unsigned REGS   = 5,
  parameter int unsigned NBITS  = 32,
  parameter int unsigned CELDAS = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [NBITS-1:0] i_RegDato,
  input  logic             i_TxDone,
  output logic [REGS-1:0]  o_RegDebug,
  output logic [7:0]       o_TxDato,
  output logic             o_TxStart,
  output logic             o_Busy,
  output logic             o_Done
);

  localparam int unsigned NBYTES = NBITS / 8;
  localparam int unsigned CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0]   LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [REGS-1:0] LAST_REG  = REGS'(CELDAS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, NEXT, DONE} state_t;

  state_t           state;
  logic [NBITS-1:0] shreg;
  logic [CW-1:0]    byte_cnt;
  logic [NBITS-1:0] shifted;

  assign shifted = shreg << 8;

  // Outputs are loaded on the edge that enters the state they belong to,
  // so every output is a flop that follows the state register exactly.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      shreg      <= '0;
      byte_cnt   <= '0;
      o_RegDebug <= '0;
      o_TxDato   <= '0;
      o_TxStart  <= 1'b0;
      o_Busy     <= 1'b0;
      o_Done     <= 1'b0;
    end else begin
      o_TxStart <= 1'b0;
      o_Done    <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state      <= LOAD;
            o_RegDebug <= '0;
            o_Busy     <= 1'b1;
          end
        end
        LOAD: begin
          shreg     <= i_RegDato;
          byte_cnt  <= '0;
          o_TxDato  <= i_RegDato[NBITS-1 -: 8];
          o_TxStart <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          state <= WAIT;
        end
        WAIT: begin
          if (i_TxDone) begin
            if (byte_cnt == LAST_BYTE) begin
              state <= NEXT;
            end else begin
              shreg     <= shifted;
              byte_cnt  <= byte_cnt + 1'b1;
              o_TxDato  <= shifted[NBITS-1 -: 8];
              o_TxStart <= 1'b1;
              state     <= SEND;
            end
          end
        end
        NEXT: begin
          if (o_RegDebug == LAST_REG) begin
            state      <= DONE;
            o_Done     <= 1'b1;
            o_RegDebug <= '0;
          end else begin
            o_RegDebug <= o_RegDebug + 1'b1;
            state      <= LOAD;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_Busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
